// File: rtl/parking_pkg.sv
// Shared types for the car-park access controller: zone codes, bay counter type,
// FSM states and the entry/exit arbitration pointer.
package parking_pkg;

  typedef logic [2:0] count_t;
  typedef logic [1:0] zone_t;

  localparam zone_t ZONE_SPEC0 = 2'd0;
  localparam zone_t ZONE_NORM0 = 2'd1;
  localparam zone_t ZONE_FLR1  = 2'd2;
  localparam zone_t ZONE_INV   = 2'd3;

  typedef enum logic {IDLE, GATE} state_t;

  typedef enum logic {PRI_EXIT, PRI_ENTRY} pri_t;

endpackage

// File: rtl/gate_timer.sv
// Barrier hold timer: loading starts a GATE_CYCLES-long busy window that drives the
// gate directly; expiring marks the last open cycle so the FSM can leave GATE on time.
module gate_timer #(
  parameter int GATE_CYCLES = 50
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  output logic busy,
  output logic expiring
);

  localparam int W = $clog2(GATE_CYCLES + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(GATE_CYCLES);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy     = (cnt_q != '0);
  assign expiring = (cnt_q == W'(1));

endmodule

// File: rtl/parking_access_ctrl.sv
// Car-park gate sequencer: arbitrates entry/exit requesters onto the single barrier,
// allocates bays by permit policy and keeps the three free-space counters.
module parking_access_ctrl
  import parking_pkg::*;
#(
  parameter int SPEC0_CAP   = 2,
  parameter int NORM0_CAP   = 3,
  parameter int FLR1_CAP    = 5,
  parameter int GATE_CYCLES = 50
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       entry_req,
  input  logic       entry_spec,
  input  logic       exit_req,
  input  logic [1:0] exit_zone,
  output logic       entry_ack,
  output logic [1:0] entry_zone,
  output logic       entry_full,
  output logic       exit_ack,
  output logic       exit_err,
  output logic       gate_open,
  output logic       lot_full,
  output logic [2:0] remain_flr_spec_0,
  output logic [2:0] remain_flr_norm_0,
  output logic [2:0] remain_flr_1
);

  if (SPEC0_CAP < 1 || SPEC0_CAP > 7 || NORM0_CAP < 1 || NORM0_CAP > 7 ||
      FLR1_CAP < 1 || FLR1_CAP > 7 || SPEC0_CAP + NORM0_CAP + FLR1_CAP > 10 ||
      GATE_CYCLES < 2) begin : g_bad_params
    $error("parking_access_ctrl: capacity or gate timing parameters out of range");
  end

  localparam count_t SPEC0_MAX = count_t'(SPEC0_CAP);
  localparam count_t NORM0_MAX = count_t'(NORM0_CAP);
  localparam count_t FLR1_MAX  = count_t'(FLR1_CAP);

  state_t state_q, state_d;
  pri_t   pri_q, pri_d;
  count_t specFree_q, specFree_d, normFree_q, normFree_d, flr1Free_q, flr1Free_d;
  logic   entryArmed_q, entryArmed_d, exitArmed_q, exitArmed_d;
  logic   entryAck_q, entryAck_d, entryFull_q, entryFull_d;
  logic   exitAck_q, exitAck_d, exitErr_q, exitErr_d;
  logic   lotFull_q, lotFull_d;
  zone_t  entryZone_q, entryZone_d;

  logic   serveEntry, serveExit, entryHasBay, exitRoom;
  zone_t  entryPick;
  logic   timerLoad, timerExpiring;

  // Arbitration and bay lookup; the pointer only matters when both sides are eligible.
  always_comb begin
    serveEntry = 1'b0;
    serveExit  = 1'b0;
    if (state_q == IDLE) begin
      if (entryArmed_q && entry_req && exitArmed_q && exit_req) begin
        serveEntry = (pri_q == PRI_ENTRY);
        serveExit  = (pri_q == PRI_EXIT);
      end else begin
        serveEntry = entryArmed_q && entry_req;
        serveExit  = exitArmed_q && exit_req;
      end
    end

    entryHasBay = 1'b1;
    entryPick   = ZONE_NORM0;
    if (entry_spec && specFree_q != '0)  entryPick = ZONE_SPEC0;
    else if (normFree_q != '0)           entryPick = ZONE_NORM0;
    else if (flr1Free_q != '0)           entryPick = ZONE_FLR1;
    else                                 entryHasBay = 1'b0;

    case (exit_zone)
      ZONE_SPEC0: exitRoom = (specFree_q < SPEC0_MAX);
      ZONE_NORM0: exitRoom = (normFree_q < NORM0_MAX);
      ZONE_FLR1:  exitRoom = (flr1Free_q < FLR1_MAX);
      default:    exitRoom = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pri_d       = pri_q;
    specFree_d  = specFree_q;
    normFree_d  = normFree_q;
    flr1Free_d  = flr1Free_q;
    entryAck_d  = 1'b0;
    entryZone_d = ZONE_SPEC0;
    entryFull_d = 1'b0;
    exitAck_d   = 1'b0;
    exitErr_d   = 1'b0;
    timerLoad   = 1'b0;

    if (state_q == GATE) begin
      if (timerExpiring) state_d = IDLE;
    end else if (serveEntry) begin
      pri_d = (pri_q == PRI_EXIT) ? PRI_ENTRY : PRI_EXIT;
      if (entryHasBay) begin
        entryAck_d  = 1'b1;
        entryZone_d = entryPick;
        timerLoad   = 1'b1;
        state_d     = GATE;
        case (entryPick)
          ZONE_SPEC0: specFree_d = specFree_q - count_t'(1);
          ZONE_NORM0: normFree_d = normFree_q - count_t'(1);
          default:    flr1Free_d = flr1Free_q - count_t'(1);
        endcase
      end else begin
        entryFull_d = 1'b1;
      end
    end else if (serveExit) begin
      pri_d = (pri_q == PRI_EXIT) ? PRI_ENTRY : PRI_EXIT;
      if (exitRoom) begin
        exitAck_d = 1'b1;
        timerLoad = 1'b1;
        state_d   = GATE;
        case (exit_zone)
          ZONE_SPEC0: specFree_d = specFree_q + count_t'(1);
          ZONE_NORM0: normFree_d = normFree_q + count_t'(1);
          default:    flr1Free_d = flr1Free_q + count_t'(1);
        endcase
      end else begin
        exitErr_d = 1'b1;
      end
    end

    // A requester re-arms only after its req has been seen low, so a held req is served once.
    entryArmed_d = (entryAck_d || entryFull_d) ? 1'b0 : (!entry_req || entryArmed_q);
    exitArmed_d  = (exitAck_d || exitErr_d)    ? 1'b0 : (!exit_req || exitArmed_q);

    lotFull_d = (specFree_d == '0) && (normFree_d == '0) && (flr1Free_d == '0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      pri_q        <= PRI_EXIT;
      specFree_q   <= SPEC0_MAX;
      normFree_q   <= NORM0_MAX;
      flr1Free_q   <= FLR1_MAX;
      entryArmed_q <= 1'b0;
      exitArmed_q  <= 1'b0;
      entryAck_q   <= 1'b0;
      entryZone_q  <= ZONE_SPEC0;
      entryFull_q  <= 1'b0;
      exitAck_q    <= 1'b0;
      exitErr_q    <= 1'b0;
      lotFull_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pri_q        <= pri_d;
      specFree_q   <= specFree_d;
      normFree_q   <= normFree_d;
      flr1Free_q   <= flr1Free_d;
      entryArmed_q <= entryArmed_d;
      exitArmed_q  <= exitArmed_d;
      entryAck_q   <= entryAck_d;
      entryZone_q  <= entryZone_d;
      entryFull_q  <= entryFull_d;
      exitAck_q    <= exitAck_d;
      exitErr_q    <= exitErr_d;
      lotFull_q    <= lotFull_d;
    end
  end

  gate_timer #(
    .GATE_CYCLES(GATE_CYCLES)
  ) u_gate_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (timerLoad),
    .busy     (gate_open),
    .expiring (timerExpiring)
  );

  assign entry_ack         = entryAck_q;
  assign entry_zone        = entryZone_q;
  assign entry_full        = entryFull_q;
  assign exit_ack          = exitAck_q;
  assign exit_err          = exitErr_q;
  assign lot_full          = lotFull_q;
  assign remain_flr_spec_0 = specFree_q;
  assign remain_flr_norm_0 = normFree_q;
  assign remain_flr_1      = flr1Free_q;

endmodule

// File: tb/tb_parking_access_ctrl.sv
// Scoreboard bench for parking_access_ctrl: stimulus pushes the expected response of each
// request, a negedge monitor pops and compares whenever an ack/reject pulse appears.
`timescale 1ns/1ps
module tb_parking_access_ctrl;

  localparam int SPEC0_CAP   = 2;
  localparam int NORM0_CAP   = 3;
  localparam int FLR1_CAP    = 5;
  localparam int GATE_CYCLES = 50;

  localparam int K_ENTRY_ACK  = 0;
  localparam int K_ENTRY_FULL = 1;
  localparam int K_EXIT_ACK   = 2;
  localparam int K_EXIT_ERR   = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       entry_req, entry_spec, exit_req;
  logic [1:0] exit_zone;
  logic       entry_ack, entry_full, exit_ack, exit_err, gate_open, lot_full;
  logic [1:0] entry_zone;
  logic [2:0] remain_flr_spec_0, remain_flr_norm_0, remain_flr_1;

  typedef struct {
    int         kind;
    logic [1:0] zone;
    logic [2:0] rs;
    logic [2:0] rn;
    logic [2:0] rf;
    logic       lot;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   monKind;
  int   assertCount = 0;
  int   failCount   = 0;

  always #5 CLK = ~CLK;

  parking_access_ctrl #(
    .SPEC0_CAP  (SPEC0_CAP),
    .NORM0_CAP  (NORM0_CAP),
    .FLR1_CAP   (FLR1_CAP),
    .GATE_CYCLES(GATE_CYCLES)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .entry_req        (entry_req),
    .entry_spec       (entry_spec),
    .exit_req         (exit_req),
    .exit_zone        (exit_zone),
    .entry_ack        (entry_ack),
    .entry_zone       (entry_zone),
    .entry_full       (entry_full),
    .exit_ack         (exit_ack),
    .exit_err         (exit_err),
    .gate_open        (gate_open),
    .lot_full         (lot_full),
    .remain_flr_spec_0(remain_flr_spec_0),
    .remain_flr_norm_0(remain_flr_norm_0),
    .remain_flr_1     (remain_flr_1)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic bit anyPulse();
    return entry_ack || entry_full || exit_ack || exit_err;
  endfunction

  task automatic pushExp(input int kind, input logic [1:0] zone, input logic [2:0] rs,
                         input logic [2:0] rn, input logic [2:0] rf, input logic lot);
    exp_t e;
    e.kind = kind;
    e.zone = zone;
    e.rs   = rs;
    e.rn   = rn;
    e.rf   = rf;
    e.lot  = lot;
    expQ.push_back(e);
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (!RST && anyPulse()) begin
      monKind = entry_ack ? K_ENTRY_ACK : entry_full ? K_ENTRY_FULL : exit_ack ? K_EXIT_ACK : K_EXIT_ERR;
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected_pulse: got kind %0d, expected no pulse", monKind);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("pulse_kind", monKind, monExp.kind);
        if (monExp.kind == K_ENTRY_ACK) checkOutput("entry_zone", entry_zone, monExp.zone);
        checkOutput("remain_spec0", remain_flr_spec_0, monExp.rs);
        checkOutput("remain_norm0", remain_flr_norm_0, monExp.rn);
        checkOutput("remain_flr1", remain_flr_1, monExp.rf);
        checkOutput("lot_full", lot_full, monExp.lot);
      end
    end
  end

  task automatic waitGate();
    int n = 0;
    while (gate_open === 1'b1 && n < 200) begin
      n++;
      @(negedge CLK);
    end
    checkOutput("gate_open_cycles", n, GATE_CYCLES);
  endtask

  // Raises one requester at a negedge, holds it until its pulse, then drops it.
  task automatic applyStimulus(input bit isEntry, input bit spec, input logic [1:0] zone,
                               input bit waitForGate);
    bit got = 1'b0;
    bit granted = 1'b0;
    if (isEntry) begin
      entry_spec = spec;
      entry_req  = 1'b1;
    end else begin
      exit_zone = zone;
      exit_req  = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (anyPulse()) begin
        got = 1'b1;
        granted = entry_ack || exit_ack;
        break;
      end
    end
    if (isEntry) entry_req = 1'b0;
    else exit_req = 1'b0;
    checkOutput("response_arrived", got, 1);
    if (got && granted) begin
      if (waitForGate) waitGate();
    end else if (got) begin
      checkOutput("gate_closed_on_reject", gate_open, 0);
      @(negedge CLK);
      checkOutput("gate_stays_closed", gate_open, 0);
    end
  endtask

  task automatic collide(input logic [1:0] ez);
    int firstAt = -1;
    int secondAt = -1;
    entry_spec = 1'b0;
    exit_zone  = ez;
    entry_req  = 1'b1;
    exit_req   = 1'b1;
    for (int i = 0; i < 200 && secondAt < 0; i++) begin
      @(negedge CLK);
      if (anyPulse()) begin
        if (entry_ack || entry_full) entry_req = 1'b0;
        else exit_req = 1'b0;
        if (firstAt < 0) firstAt = i;
        else secondAt = i;
      end
    end
    entry_req = 1'b0;
    exit_req  = 1'b0;
    checkOutput("collision_gap", secondAt - firstAt, GATE_CYCLES + 1);
    waitGate();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    RST        = 1'b1;
    entry_req  = 1'b0;
    exit_req   = 1'b0;
    entry_spec = 1'b0;
    exit_zone  = 2'd0;
    repeat (3) @(negedge CLK);
    checkOutput("reset_pulses", {entry_ack, entry_full, exit_ack, exit_err}, 4'b0000);
    checkOutput("reset_gate", gate_open, 0);
    checkOutput("reset_lot_full", lot_full, 0);
    checkOutput("reset_entry_zone", entry_zone, 0);
    checkOutput("reset_remain", {remain_flr_spec_0, remain_flr_norm_0, remain_flr_1}, {3'd2, 3'd3, 3'd5});
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    $display("[TB] five non-permit entries");
    pushExp(K_ENTRY_ACK, 2'd1, 3'd2, 3'd2, 3'd5, 1'b0); applyStimulus(1, 0, 2'd0, 1);
    pushExp(K_ENTRY_ACK, 2'd1, 3'd2, 3'd1, 3'd5, 1'b0); applyStimulus(1, 0, 2'd0, 1);
    pushExp(K_ENTRY_ACK, 2'd1, 3'd2, 3'd0, 3'd5, 1'b0); applyStimulus(1, 0, 2'd0, 1);
    pushExp(K_ENTRY_ACK, 2'd2, 3'd2, 3'd0, 3'd4, 1'b0); applyStimulus(1, 0, 2'd0, 1);
    pushExp(K_ENTRY_ACK, 2'd2, 3'd2, 3'd0, 3'd3, 1'b0); applyStimulus(1, 0, 2'd0, 1);

    $display("[TB] fill remaining bays, last one on floor 1");
    pushExp(K_ENTRY_ACK, 2'd0, 3'd1, 3'd0, 3'd3, 1'b0); applyStimulus(1, 1, 2'd0, 1);
    pushExp(K_ENTRY_ACK, 2'd0, 3'd0, 3'd0, 3'd3, 1'b0); applyStimulus(1, 1, 2'd0, 1);
    pushExp(K_ENTRY_ACK, 2'd2, 3'd0, 3'd0, 3'd2, 1'b0); applyStimulus(1, 1, 2'd0, 1);
    pushExp(K_ENTRY_ACK, 2'd2, 3'd0, 3'd0, 3'd1, 1'b0); applyStimulus(1, 0, 2'd0, 1);
    pushExp(K_ENTRY_ACK, 2'd2, 3'd0, 3'd0, 3'd0, 1'b1); applyStimulus(1, 1, 2'd0, 1);

    $display("[TB] entries and bad exit against a full lot");
    pushExp(K_ENTRY_FULL, 2'd0, 3'd0, 3'd0, 3'd0, 1'b1); applyStimulus(1, 0, 2'd0, 1);
    pushExp(K_ENTRY_FULL, 2'd0, 3'd0, 3'd0, 3'd0, 1'b1); applyStimulus(1, 1, 2'd0, 1);
    pushExp(K_EXIT_ERR,   2'd0, 3'd0, 3'd0, 3'd0, 1'b1); applyStimulus(0, 0, 2'd3, 1);

    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("rereset_remain", {remain_flr_spec_0, remain_flr_norm_0, remain_flr_1}, {3'd2, 3'd3, 3'd5});
    checkOutput("rereset_lot_full", lot_full, 0);

    $display("[TB] exit rejects, then collisions");
    pushExp(K_EXIT_ERR,  2'd0, 3'd2, 3'd3, 3'd5, 1'b0); applyStimulus(0, 0, 2'd0, 1);
    pushExp(K_EXIT_ERR,  2'd0, 3'd2, 3'd3, 3'd5, 1'b0); applyStimulus(0, 0, 2'd3, 1);
    pushExp(K_ENTRY_ACK, 2'd1, 3'd2, 3'd2, 3'd5, 1'b0); applyStimulus(1, 0, 2'd0, 1);
    pushExp(K_ENTRY_ACK, 2'd1, 3'd2, 3'd1, 3'd5, 1'b0); applyStimulus(1, 0, 2'd0, 1);
    pushExp(K_EXIT_ACK,  2'd0, 3'd2, 3'd2, 3'd5, 1'b0);
    pushExp(K_ENTRY_ACK, 2'd1, 3'd2, 3'd1, 3'd5, 1'b0);
    collide(2'd1);
    pushExp(K_EXIT_ERR,  2'd0, 3'd2, 3'd1, 3'd5, 1'b0); applyStimulus(0, 0, 2'd3, 1);
    pushExp(K_ENTRY_ACK, 2'd1, 3'd2, 3'd0, 3'd5, 1'b0);
    pushExp(K_EXIT_ACK,  2'd0, 3'd2, 3'd1, 3'd5, 1'b0);
    collide(2'd1);

    $display("[TB] held entry request, reset mid-gate");
    pushExp(K_ENTRY_ACK, 2'd1, 3'd2, 3'd0, 3'd5, 1'b0);
    entry_spec = 1'b0;
    entry_req  = 1'b1;
    n = 0;
    repeat (200) begin
      @(negedge CLK);
      if (entry_ack) n++;
    end
    checkOutput("held_req_acks", n, 1);
    pushExp(K_EXIT_ACK, 2'd0, 3'd2, 3'd1, 3'd5, 1'b0); applyStimulus(0, 0, 2'd1, 0);
    repeat (10) @(negedge CLK);
    checkOutput("gate_open_before_reset", gate_open, 1);
    RST = 1'b1;
    #1;
    checkOutput("gate_drops_on_reset", gate_open, 0);
    checkOutput("reset_mid_gate_remain", {remain_flr_spec_0, remain_flr_norm_0, remain_flr_1}, {3'd2, 3'd3, 3'd5});
    @(negedge CLK);
    RST = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge CLK);
      if (entry_ack || entry_full) n++;
    end
    checkOutput("held_through_reset_responses", n, 0);
    entry_req = 1'b0;
    @(negedge CLK);
    pushExp(K_ENTRY_ACK, 2'd1, 3'd2, 3'd2, 3'd5, 1'b0); applyStimulus(1, 0, 2'd0, 1);

    repeat (2) @(negedge CLK);
    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
